branch_unit_bht: RTL and testbench
==================================

// Module: branch_unit_bht
// PURPOSE
//  Parametrised branch resolver plus bimodal predictor for the pipelined core.
//  Resolves all six RV32I branch conditions in EX and registers taken/mispredict flags.
//  Keeps a table of 2-bit saturating counters, read at IF, updated at EX resolution.
//  Sits between the EX ALU operand muxes and the IF next-PC/flush logic.
// PARAMETERS
//  XLEN         32     operand and PC width
//  BHT_ENTRIES  64     counter table depth; power of 2, >= 2; IDX = log2(BHT_ENTRIES)
//  CNT_INIT     2'b01  reset value of every counter (weakly not-taken)
// PORTS
//  clk_i            in   1     clock, rising edge
//  rst_i            in   1     asynchronous reset, active-high
//  if_pc_i          in   XLEN  fetch PC for prediction lookup
//  if_pred_taken_o  out  1     combinational prediction for if_pc_i
//  ex_branch_i      in   1     a branch resolves this cycle
//  ex_f3_i          in   3     funct3 of the resolving branch
//  ex_pc_i          in   XLEN  PC of the resolving branch
//  ex_rs1_i         in   XLEN  operand rs1
//  ex_rs2_i         in   XLEN  operand rs2
//  ex_pred_taken_i  in   1     prediction carried down the pipe with the branch
//  br_valid_o       out  1     registered: legal branch resolved last cycle
//  br_taken_o       out  1     registered: resolved outcome
//  br_mispredict_o  out  1     registered: outcome != ex_pred_taken_i
//  br_illegal_o     out  1     registered: ex_branch_i with f3 = 010 or 011
// BEHAVIOUR
//  - Index = pc[IDX+1:2] for both IF lookup and EX update.
//  - Conditions: 000 beq a==b; 001 bne a!=b; 100 blt signed a<b; 101 bge signed a>=b;
//    110 bltu unsigned a<b; 111 bgeu unsigned a>=b. Signed compare uses $signed.
//  - Counter: 00 SNT, 01 WNT, 10 WT, 11 ST; predict taken iff MSB = 1.
//  - Update on clk_i edge when ex_branch_i and f3 legal: taken -> +1 saturating at 11,
//    not-taken -> -1 saturating at 00. Illegal f3: no table update.
//  - Latency: flags are valid exactly one cycle after ex_branch_i; single-cycle pulses.
//  - ex_branch_i = 0: next cycle br_valid_o, br_taken_o, br_mispredict_o, br_illegal_o = 0.
//  - Illegal f3: br_illegal_o = 1, br_valid_o = br_taken_o = br_mispredict_o = 0.
//  - Same index read and written in one cycle: lookup returns the pre-update value.
//  - Back-to-back branches every cycle are supported; no stall output.
//  - Reset (async, any time, incl. mid-update): all counters <= CNT_INIT, all outputs 0;
//    an update coincident with reset is dropped.
// CONFIGURATION
//  BRANCH_STATS_EN defined: adds ports stat_branches_o [31:0] and stat_mispred_o [31:0];
//    +1 per legal resolved branch and per mispredict; saturate at 32'hFFFF_FFFF;
//    cleared by rst_i; both update in the same cycle as the table.
//  BRANCH_STATS_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  - Reset: rst_i high mid-run -> all flags 0, lookup of any PC gives 0 (CNT_INIT 01).
//  - All f3: rs1=32'hFFFF_FFFF, rs2=1 -> beq 0, bne 1, blt 1, bge 0, bltu 0, bgeu 1.
//  - Saturation: 3 taken at pc 0x40 -> predict 1; 3 not-taken -> predict 0; stays 00.
//  - Mispredict: ex_pred_taken_i=0, beq rs1=rs2=5 -> next cycle taken=1, mispredict=1.
//  - Aliasing/bypass: pc 0x40 and 0x40+4*BHT_ENTRIES share entry; same-cycle read old.
//  - Illegal f3=010 -> br_illegal_o=1, counter unchanged; stats (if enabled) unchanged.

Source files
------------

// File: rtl/branch_unit_bht.sv
// branch_unit_bht: RV32I branch resolver with a bimodal 2-bit counter predictor.
// Optional macro BRANCH_STATS_EN adds saturating branch/mispredict statistic counters.
module branch_unit_bht #(
    parameter int         XLEN        = 32,
    parameter int         BHT_ENTRIES = 64,
    parameter logic [1:0] CNT_INIT    = 2'b01
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [XLEN-1:0] if_pc_i,
    output logic            if_pred_taken_o,
    input  logic            ex_branch_i,
    input  logic [2:0]      ex_f3_i,
    input  logic [XLEN-1:0] ex_pc_i,
    input  logic [XLEN-1:0] ex_rs1_i,
    input  logic [XLEN-1:0] ex_rs2_i,
    input  logic            ex_pred_taken_i,
    output logic            br_valid_o,
    output logic            br_taken_o,
    output logic            br_mispredict_o,
    output logic            br_illegal_o
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]     stat_branches_o,
    output logic [31:0]     stat_mispred_o
`endif
);
    localparam int IDX = $clog2(BHT_ENTRIES);

    logic [1:0]     bht [BHT_ENTRIES];
    logic [IDX-1:0] if_idx, ex_idx;
    logic           legal, upd, cond, taken, mis;
    logic [1:0]     cur_cnt;
    logic           unused_pc;

    assign if_idx    = if_pc_i[IDX+1:2];
    assign ex_idx    = ex_pc_i[IDX+1:2];
    assign unused_pc = ^{if_pc_i[XLEN-1:IDX+2], if_pc_i[1:0], ex_pc_i[XLEN-1:IDX+2], ex_pc_i[1:0]};

    // The lookup reads the array directly, so a same-cycle update is not visible until the next cycle.
    assign if_pred_taken_o = bht[if_idx][1];
    assign cur_cnt         = bht[ex_idx];

    // Resolve the branch: f3[2] picks relational vs equality, f3[1] unsigned, f3[0] inverts.
    always_comb begin
        legal = ex_f3_i[2:1] != 2'b01;
        cond  = ex_f3_i[2] ? (ex_f3_i[1] ? (ex_rs1_i < ex_rs2_i) : ($signed(ex_rs1_i) < $signed(ex_rs2_i)))
                           : (ex_rs1_i == ex_rs2_i);
        taken = cond ^ ex_f3_i[0];
        mis   = taken ^ ex_pred_taken_i;
        upd   = ex_branch_i && legal;
    end

    // Train the counter of the resolving branch, saturating at both ends.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= CNT_INIT;
        end else if (upd) begin
            bht[ex_idx] <= taken ? ((cur_cnt == 2'b11) ? 2'b11 : cur_cnt + 2'b01)
                                 : ((cur_cnt == 2'b00) ? 2'b00 : cur_cnt - 2'b01);
        end
    end

    // Register single-cycle resolution flags.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            br_valid_o      <= 1'b0;
            br_taken_o      <= 1'b0;
            br_mispredict_o <= 1'b0;
            br_illegal_o    <= 1'b0;
        end else begin
            br_valid_o      <= upd;
            br_taken_o      <= upd && taken;
            br_mispredict_o <= upd && mis;
            br_illegal_o    <= ex_branch_i && !legal;
        end
    end

`ifdef BRANCH_STATS_EN
    // Count legal branches and mispredicts, sticking at all-ones.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_branches_o <= '0;
            stat_mispred_o  <= '0;
        end else if (upd) begin
            stat_branches_o <= (&stat_branches_o) ? stat_branches_o : stat_branches_o + 32'd1;
            if (mis) stat_mispred_o <= (&stat_mispred_o) ? stat_mispred_o : stat_mispred_o + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_branch_unit_bht.sv
// tb_branch_unit_bht: vector table, hand sequences and randomized model check of branch_unit_bht.
module tb_branch_unit_bht;
    logic        clk_i = 0;
    logic        rst_i;
    logic [31:0] if_pc_i, ex_pc_i, ex_rs1_i, ex_rs2_i;
    logic        if_pred_taken_o, ex_branch_i, ex_pred_taken_i;
    logic [2:0]  ex_f3_i;
    logic        br_valid_o, br_taken_o, br_mispredict_o, br_illegal_o;
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches_o, stat_mispred_o;
`endif

    int checks = 0;
    int errors = 0;
    int cnt[64];
    int n_br = 0;
    int n_mis = 0;

    always #5 clk_i = ~clk_i;

    branch_unit_bht dut (
        .clk_i(clk_i), .rst_i(rst_i), .if_pc_i(if_pc_i), .if_pred_taken_o(if_pred_taken_o),
        .ex_branch_i(ex_branch_i), .ex_f3_i(ex_f3_i), .ex_pc_i(ex_pc_i), .ex_rs1_i(ex_rs1_i),
        .ex_rs2_i(ex_rs2_i), .ex_pred_taken_i(ex_pred_taken_i), .br_valid_o(br_valid_o),
        .br_taken_o(br_taken_o), .br_mispredict_o(br_mispredict_o), .br_illegal_o(br_illegal_o)
`ifdef BRANCH_STATS_EN
        , .stat_branches_o(stat_branches_o), .stat_mispred_o(stat_mispred_o)
`endif
    );

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        bit          pred;
        bit          et;
        bit          em;
        bit          ei;
        string       nm;
    } vec_t;

    function automatic int idx_of(logic [31:0] pc);
        return int'((pc >> 2) % 64);
    endfunction

    function automatic bit ref_taken(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
        case (f3)
            3'b000: return a == b;
            3'b001: return a != b;
            3'b100: return $signed(a) < $signed(b);
            3'b101: return $signed(a) >= $signed(b);
            3'b110: return a < b;
            3'b111: return a >= b;
            default: return 0;
        endcase
    endfunction

    function automatic bit is_legal(logic [2:0] f3);
        return !(f3 == 3'b010 || f3 == 3'b011);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic pred_chk(input string nm, input logic [31:0] pc);
        if_pc_i = pc;
        #1;
        chk(nm, {31'd0, if_pred_taken_o}, {31'd0, cnt[idx_of(pc)] >= 2});
    endtask

    task automatic set_ex(input bit br, input logic [2:0] f3, input logic [31:0] pc,
                          input logic [31:0] a, input logic [31:0] b, input bit pred);
        ex_branch_i = br; ex_f3_i = f3; ex_pc_i = pc;
        ex_rs1_i = a; ex_rs2_i = b; ex_pred_taken_i = pred;
    endtask

    task automatic finish(input bit ev, input bit et, input bit em, input bit ei, input string nm);
        bit t;
        int i;
        @(posedge clk_i);
        if (ex_branch_i && is_legal(ex_f3_i)) begin
            t = ref_taken(ex_f3_i, ex_rs1_i, ex_rs2_i);
            i = idx_of(ex_pc_i);
            cnt[i] = t ? ((cnt[i] == 3) ? 3 : cnt[i] + 1) : ((cnt[i] == 0) ? 0 : cnt[i] - 1);
            n_br++;
            if (t != ex_pred_taken_i) n_mis++;
        end
        #1;
        chk({nm, ".valid"}, {31'd0, br_valid_o}, {31'd0, ev});
        chk({nm, ".taken"}, {31'd0, br_taken_o}, {31'd0, et});
        chk({nm, ".mispredict"}, {31'd0, br_mispredict_o}, {31'd0, em});
        chk({nm, ".illegal"}, {31'd0, br_illegal_o}, {31'd0, ei});
    endtask

    task automatic branch_auto(input bit br, input logic [2:0] f3, input logic [31:0] pc,
                               input logic [31:0] a, input logic [31:0] b, input bit pred, input string nm);
        bit lg, t;
        lg = br && is_legal(f3);
        t  = ref_taken(f3, a, b);
        set_ex(br, f3, pc, a, b, pred);
        finish(lg, lg && t, lg && (t != pred), br && !lg, nm);
    endtask

    task automatic stats_chk(input string nm);
`ifdef BRANCH_STATS_EN
        chk({nm, ".stat_branches"}, stat_branches_o, n_br);
        chk({nm, ".stat_mispred"}, stat_mispred_o, n_mis);
`else
        if (nm.len() == 0) $display("stats disabled");
`endif
    endtask

    initial begin
        vec_t v[12];
        logic [31:0] pc, a, b;
        v[0]  = '{3'b000, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 0, "beq_m1_1"};
        v[1]  = '{3'b001, 32'hFFFF_FFFF, 32'd1, 0, 1, 1, 0, "bne_m1_1"};
        v[2]  = '{3'b100, 32'hFFFF_FFFF, 32'd1, 1, 1, 0, 0, "blt_m1_1"};
        v[3]  = '{3'b101, 32'hFFFF_FFFF, 32'd1, 1, 0, 1, 0, "bge_m1_1"};
        v[4]  = '{3'b110, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 0, "bltu_m1_1"};
        v[5]  = '{3'b111, 32'hFFFF_FFFF, 32'd1, 1, 1, 0, 0, "bgeu_m1_1"};
        v[6]  = '{3'b010, 32'd3, 32'd3, 1, 0, 0, 1, "illegal_010"};
        v[7]  = '{3'b011, 32'd3, 32'd4, 0, 0, 0, 1, "illegal_011"};
        v[8]  = '{3'b000, 32'd5, 32'd5, 0, 1, 1, 0, "beq_mispredict"};
        v[9]  = '{3'b100, 32'd7, 32'd7, 0, 0, 0, 0, "blt_equal"};
        v[10] = '{3'b101, 32'd7, 32'd7, 1, 1, 0, 0, "bge_equal"};
        v[11] = '{3'b110, 32'd0, 32'hFFFF_FFFF, 1, 1, 0, 0, "bltu_0_max"};
        for (int i = 0; i < 64; i++) cnt[i] = 1;

        rst_i = 1;
        if_pc_i = 32'h40;
        set_ex(0, 3'b000, 32'h0, 32'h0, 32'h0, 0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 0;
        finish(0, 0, 0, 0, "reset_idle");
        pred_chk("reset_pred_40", 32'h40);
        stats_chk("reset");

        for (int i = 0; i < 12; i++) begin
            set_ex(1, v[i].f3, 32'h100, v[i].a, v[i].b, v[i].pred);
            finish(!v[i].ei, v[i].et, v[i].em, v[i].ei, v[i].nm);
        end
        set_ex(0, 3'b000, 32'h100, 32'd5, 32'd5, 0);
        finish(0, 0, 0, 0, "no_branch");
        stats_chk("table");

        for (int i = 0; i < 3; i++) branch_auto(1, 3'b000, 32'h40, 32'd0, 32'd0, 0, "sat_up");
        pred_chk("sat_up_3", 32'h40);
        for (int i = 0; i < 2; i++) branch_auto(1, 3'b000, 32'h40, 32'd0, 32'd0, 1, "sat_up_more");
        branch_auto(1, 3'b001, 32'h40, 32'd0, 32'd0, 1, "sat_top_dec");
        pred_chk("sat_top_hold", 32'h40);
        for (int i = 0; i < 3; i++) branch_auto(1, 3'b001, 32'h40, 32'd0, 32'd0, 1, "sat_down");
        pred_chk("sat_down_3", 32'h40);
        branch_auto(1, 3'b001, 32'h40, 32'd0, 32'd0, 0, "sat_floor");
        pred_chk("sat_floor_hold", 32'h40);
        branch_auto(1, 3'b000, 32'h40, 32'd0, 32'd0, 0, "to_wnt");

        set_ex(1, 3'b000, 32'h40, 32'd9, 32'd9, 0);
        if_pc_i = 32'h40;
        #1;
        chk("bypass_old_value", {31'd0, if_pred_taken_o}, 32'd0);
        finish(1, 1, 1, 0, "bypass_update");
        pred_chk("bypass_after", 32'h40);
        pred_chk("alias_read_140", 32'h40 + 4 * 64);
        branch_auto(1, 3'b001, 32'h40 + 4 * 64, 32'd1, 32'd1, 1, "alias_update");
        pred_chk("alias_effect_40", 32'h40);
        branch_auto(1, 3'b000, 32'h40, 32'd1, 32'd1, 0, "to_wt");
        stats_chk("pre_illegal");
        set_ex(1, 3'b010, 32'h40, 32'd0, 32'd1, 0);
        finish(0, 0, 0, 1, "illegal_hold");
        chk("illegal_no_update", {31'd0, if_pred_taken_o}, 32'd1);
        stats_chk("post_illegal");

        for (int i = 0; i < 400; i++) begin
            pc = 32'h40 + 4 * $urandom_range(0, 7) + ($urandom_range(0, 1) ? 32'd256 : 32'd0);
            a  = $urandom;
            b  = ($urandom_range(0, 2) == 0) ? a : $urandom;
            set_ex($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), pc, a, b, 1'($urandom_range(0, 1)));
            pred_chk("rand_pred", 32'h40 + 4 * $urandom_range(0, 7) + ($urandom_range(0, 1) ? 32'd256 : 32'd0));
            branch_auto(ex_branch_i, ex_f3_i, pc, a, b, ex_pred_taken_i, "rand");
        end
        stats_chk("random");

        branch_auto(1, 3'b000, 32'h40, 32'd2, 32'd2, 0, "pre_reset");
        set_ex(1, 3'b000, 32'h40, 32'd2, 32'd2, 0);
        rst_i = 1;
        #1;
        chk("async_rst_valid", {31'd0, br_valid_o}, 32'd0);
        chk("async_rst_taken", {31'd0, br_taken_o}, 32'd0);
        chk("async_rst_mispredict", {31'd0, br_mispredict_o}, 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 0;
        ex_branch_i = 0;
        for (int i = 0; i < 64; i++) cnt[i] = 1;
        n_br = 0;
        n_mis = 0;
        for (int i = 0; i < 8; i++) begin
            if_pc_i = 32'h40 + 4 * i;
            #1;
            chk("rst_pred_zero", {31'd0, if_pred_taken_o}, 32'd0);
        end
        finish(0, 0, 0, 0, "rst_flags");
        stats_chk("after_reset");
        branch_auto(1, 3'b000, 32'h40, 32'd0, 32'd0, 0, "post_rst_train");
        pred_chk("post_rst_pred", 32'h40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
